// File: rtl/cpu_datapath_pkg.sv
// Shared datapath definitions used by the operand register file, the 2:1
// operand mux and the ALU.
package cpu_datapath_pkg;

    // Datapath word width and register-index width.
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned REG_ADDR_W = 3;
    localparam int unsigned REG_DEPTH  = 1 << REG_ADDR_W;

    typedef logic [DATA_W-1:0]     data_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // Index of the hard-wired zero register when that option is enabled.
    localparam reg_addr_t ZERO_ADDR = REG_ADDR_W'(0);

    // Writeback bus payload from the ALU into the register file.
    typedef struct packed {
        logic      wr_en;
        reg_addr_t wr_addr;
        data_t     wr_data;
    } reg_wr_t;

    // True when an access to addr targets the hard-wired zero register.
    function automatic logic is_zero_reg(input reg_addr_t addr, input logic zero_reg_en);
        return zero_reg_en && (addr == ZERO_ADDR);
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port of the operand register file: selects a storage
// entry, optionally forwards a same-edge write, and holds the result in an
// output register until the next read request.
// Build option: OPERAND_REGFILE_BYPASS_EN enables write-through forwarding.
module regfile_read_port #(
    parameter int unsigned DATA_W   = cpu_datapath_pkg::DATA_W,
    parameter int unsigned ADDR_W   = cpu_datapath_pkg::REG_ADDR_W,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   rd_en_i,
    input  logic [ADDR_W-1:0]                      rd_addr_i,
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]     mem_i,
`ifdef OPERAND_REGFILE_BYPASS_EN
    input  logic                                   wr_en_i,
    input  logic [ADDR_W-1:0]                      wr_addr_i,
    input  logic [DATA_W-1:0]                      wr_data_i,
`endif
    output logic [DATA_W-1:0]                      rd_data_o
);

    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] sel_data_c;
    logic              zero_hit_c;

    // Select the addressed word, apply forwarding and zero-register rules.
    always_comb begin
        zero_hit_c = ZERO_REG && (rd_addr_i == ADDR_W'(0));
        sel_data_c = mem_i[rd_addr_i];
`ifdef OPERAND_REGFILE_BYPASS_EN
        if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
            sel_data_c = wr_data_i;
        end
`endif
        if (zero_hit_c) begin
            sel_data_c = '0;
        end
        rd_data_d = rd_en_i ? sel_data_c : rd_data_q;
    end

    // Output register: loads on a read request, otherwise holds for the mux.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/operand_register_file.sv
// Operand register file: 2**ADDR_W x DATA_W storage with one write port from
// writeback and two registered read ports feeding the 2:1 operand mux.
// Build option: OPERAND_REGFILE_BYPASS_EN makes a same-edge read of the
// address being written return the new data instead of the old value.
module operand_register_file #(
    parameter int unsigned DATA_W   = cpu_datapath_pkg::DATA_W,
    parameter int unsigned ADDR_W   = cpu_datapath_pkg::REG_ADDR_W,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_valid
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic [DEPTH-1:0][DATA_W-1:0] mem_d;
    logic                         rd_valid_q;
    logic                         rd_valid_d;
    logic                         wr_drop_c;

    // Next-state for storage and the read-valid pulse.
    always_comb begin
        mem_d      = mem_q;
        rd_valid_d = rd_en;
        wr_drop_c  = ZERO_REG && (wr_addr == ADDR_W'(0));
        if (wr_en && !wr_drop_c) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Storage and valid registers; reset clears every entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_valid = rd_valid_q;

    // Port 1 drives the mux data1 input.
    regfile_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_rd_port1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr1),
        .mem_i     (mem_q),
`ifdef OPERAND_REGFILE_BYPASS_EN
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
`endif
        .rd_data_o (rd_data1)
    );

    // Port 2 drives the mux data2 input.
    regfile_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_rd_port2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr2),
        .mem_i     (mem_q),
`ifdef OPERAND_REGFILE_BYPASS_EN
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
`endif
        .rd_data_o (rd_data2)
    );

endmodule

// File: tb/tb_operand_register_file.sv
// Self-checking bench for operand_register_file. Two instances share the same
// stimulus: index 0 has ZERO_REG=1, index 1 has ZERO_REG=0.
module tb_operand_register_file;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [2:0] rd_addr1;
    logic [2:0] rd_addr2;

    logic [7:0] z_d1, z_d2, n_d1, n_d2;
    logic       z_v, n_v;

    int checks = 0;
    int errors = 0;

    // Reference model: plain register arrays plus the last read results.
    logic [7:0] mdl    [2][8];
    logic [7:0] exp_d1 [2];
    logic [7:0] exp_d2 [2];
    logic       exp_v;

    always #5 clk = ~clk;

    operand_register_file #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b1)) dut_z (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(z_d1), .rd_data2(z_d2), .rd_valid(z_v)
    );

    operand_register_file #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b0)) dut_n (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(n_d1), .rd_data2(n_d2), .rd_valid(n_v)
    );

    function automatic logic [7:0] act_d1(input int i);
        return (i == 0) ? z_d1 : n_d1;
    endfunction

    function automatic logic [7:0] act_d2(input int i);
        return (i == 0) ? z_d2 : n_d2;
    endfunction

    function automatic logic act_v(input int i);
        return (i == 0) ? z_v : n_v;
    endfunction

    // What a read of address a returns on an edge that also carries (we, wa, wd).
    function automatic logic [7:0] mdl_read(input int i, input logic [2:0] a,
                                            input logic we, input logic [2:0] wa,
                                            input logic [7:0] wd);
        if (i == 0 && a == 3'd0) return 8'h00;
`ifdef OPERAND_REGFILE_BYPASS_EN
        if (we && wa == a) return wd;
`endif
        return mdl[i][a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int a = 0; a < 8; a++) mdl[i][a] = 8'h00;
            exp_d1[i] = 8'h00;
            exp_d2[i] = 8'h00;
        end
        exp_v = 1'b0;
    endtask

    // Drive one clock of stimulus, advance the model, return 1 time unit after the edge.
    task automatic step(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                        input logic re, input logic [2:0] a1, input logic [2:0] a2);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_addr1 = a1; rd_addr2 = a2;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (re) begin
                exp_d1[i] = mdl_read(i, a1, we, wa, wd);
                exp_d2[i] = mdl_read(i, a2, we, wa, wd);
            end
            if (we && !(i == 0 && wa == 3'd0)) mdl[i][wa] = wd;
        end
        exp_v = re;
        #1;
    endtask

    task automatic test_reset();
        // Reset state straight out of power-on reset.
        for (int i = 0; i < 2; i++) begin
            checks += 3;
            if (act_d1(i) !== 8'h00) begin errors++; $display("FAIL por_d1 inst%0d got %h exp 00", i, act_d1(i)); end
            if (act_d2(i) !== 8'h00) begin errors++; $display("FAIL por_d2 inst%0d got %h exp 00", i, act_d2(i)); end
            if (act_v(i)  !== 1'b0)  begin errors++; $display("FAIL por_valid inst%0d got %b exp 0", i, act_v(i)); end
        end
        #11 reset_n = 1'b1;
        step(1'b1, 3'd1, 8'h5A, 1'b0, 3'd0, 3'd0);
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 3'd1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_d1(i) !== 8'h5A) begin errors++; $display("FAIL pre_reset_d1 inst%0d got %h exp 5a", i, act_d1(i)); end
        end
        // Mid-cycle reset with a read request still asserted.
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            checks += 3;
            if (act_d1(i) !== 8'h00) begin errors++; $display("FAIL async_rst_d1 inst%0d got %h exp 00", i, act_d1(i)); end
            if (act_d2(i) !== 8'h00) begin errors++; $display("FAIL async_rst_d2 inst%0d got %h exp 00", i, act_d2(i)); end
            if (act_v(i)  !== 1'b0)  begin errors++; $display("FAIL async_rst_valid inst%0d got %b exp 0", i, act_v(i)); end
        end
        #1 reset_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            step(1'b0, 3'd0, 8'h00, 1'b1, 3'(a), 3'(7 - a));
            for (int i = 0; i < 2; i++) begin
                checks += 3;
                if (act_d1(i) !== 8'h00) begin errors++; $display("FAIL rst_clear_d1 inst%0d addr %0d got %h exp 00", i, a, act_d1(i)); end
                if (act_d2(i) !== 8'h00) begin errors++; $display("FAIL rst_clear_d2 inst%0d addr %0d got %h exp 00", i, 7 - a, act_d2(i)); end
                if (act_v(i)  !== 1'b1)  begin errors++; $display("FAIL rst_clear_valid inst%0d got %b exp 1", i, act_v(i)); end
            end
        end
    endtask

    task automatic test_read_hold();
        step(1'b1, 3'd5, 8'h3C, 1'b0, 3'd0, 3'd0);
        step(1'b1, 3'd2, 8'hA7, 1'b0, 3'd0, 3'd0);
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 3'd2);
        for (int i = 0; i < 2; i++) begin
            checks += 3;
            if (act_d1(i) !== 8'h3C) begin errors++; $display("FAIL read_d1 inst%0d got %h exp 3c", i, act_d1(i)); end
            if (act_d2(i) !== 8'hA7) begin errors++; $display("FAIL read_d2 inst%0d got %h exp a7", i, act_d2(i)); end
            if (act_v(i)  !== 1'b1)  begin errors++; $display("FAIL read_valid inst%0d got %b exp 1", i, act_v(i)); end
        end
        // Idle cycle with different addresses: data must hold, valid drops.
        step(1'b0, 3'd0, 8'h00, 1'b0, 3'd1, 3'd3);
        for (int i = 0; i < 2; i++) begin
            checks += 3;
            if (act_d1(i) !== 8'h3C) begin errors++; $display("FAIL hold_d1 inst%0d got %h exp 3c", i, act_d1(i)); end
            if (act_d2(i) !== 8'hA7) begin errors++; $display("FAIL hold_d2 inst%0d got %h exp a7", i, act_d2(i)); end
            if (act_v(i)  !== 1'b0)  begin errors++; $display("FAIL hold_valid inst%0d got %b exp 0", i, act_v(i)); end
        end
    endtask

    task automatic test_zero_reg();
        logic [7:0] want [2];
        want[0] = 8'h00;
        want[1] = 8'hFF;
        step(1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 3'd0);
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 3'd0);
        for (int i = 0; i < 2; i++) begin
            checks += 2;
            if (act_d1(i) !== want[i]) begin errors++; $display("FAIL zero_reg_d1 inst%0d got %h exp %h", i, act_d1(i), want[i]); end
            if (act_d2(i) !== want[i]) begin errors++; $display("FAIL zero_reg_d2 inst%0d got %h exp %h", i, act_d2(i), want[i]); end
        end
    endtask

    task automatic test_collision();
        logic [7:0] want;
`ifdef OPERAND_REGFILE_BYPASS_EN
        want = 8'h99;
`else
        want = 8'h11;
`endif
        step(1'b1, 3'd3, 8'h11, 1'b0, 3'd0, 3'd0);
        // Port 1 collides with the write, port 2 reads an unrelated register.
        step(1'b1, 3'd3, 8'h99, 1'b1, 3'd3, 3'd5);
        for (int i = 0; i < 2; i++) begin
            checks += 3;
            if (act_d1(i) !== want) begin errors++; $display("FAIL collide_d1 inst%0d got %h exp %h", i, act_d1(i), want); end
            if (act_d1(i) !== exp_d1[i]) begin errors++; $display("FAIL collide_model_d1 inst%0d got %h exp %h", i, act_d1(i), exp_d1[i]); end
            if (act_d2(i) !== 8'h3C) begin errors++; $display("FAIL collide_other_d2 inst%0d got %h exp 3c", i, act_d2(i)); end
        end
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 3'd3);
        for (int i = 0; i < 2; i++) begin
            checks += 2;
            if (act_d1(i) !== 8'h99) begin errors++; $display("FAIL after_collide_d1 inst%0d got %h exp 99", i, act_d1(i)); end
            if (act_d2(i) !== 8'h99) begin errors++; $display("FAIL after_collide_d2 inst%0d got %h exp 99", i, act_d2(i)); end
        end
    endtask

    task automatic test_back_to_back();
        logic       mux_sel;
        logic [7:0] mux_out;
        logic [7:0] mux_exp;
        for (int a = 1; a < 8; a++) begin
            step(1'b1, 3'(a), (a <= 4) ? 8'(a) : 8'($urandom_range(255)), 1'b0, 3'd0, 3'd0);
        end
        mux_sel = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 3'd0, 8'h00, 1'b1, 3'(k), 3'((k + 4) % 8));
            for (int i = 0; i < 2; i++) begin
                checks += 3;
                if (act_d1(i) !== 8'(k))     begin errors++; $display("FAIL b2b_d1 inst%0d cyc%0d got %h exp %h", i, k, act_d1(i), 8'(k)); end
                if (act_d2(i) !== exp_d2[i]) begin errors++; $display("FAIL b2b_d2 inst%0d cyc%0d got %h exp %h", i, k, act_d2(i), exp_d2[i]); end
                if (act_v(i)  !== 1'b1)      begin errors++; $display("FAIL b2b_valid inst%0d cyc%0d got %b exp 1", i, k, act_v(i)); end
            end
            // Downstream 2:1 operand mux with a toggling select.
            mux_out = mux_sel ? z_d2 : z_d1;
            mux_exp = mux_sel ? exp_d2[0] : 8'(k);
            checks++;
            if (mux_out !== mux_exp) begin errors++; $display("FAIL mux_out cyc%0d sel %b got %h exp %h", k, mux_sel, mux_out, mux_exp); end
            mux_sel = ~mux_sel;
        end
    endtask

    task automatic test_reset_streaming();
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 3'd2);
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 3'd4);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            checks += 3;
            if (act_d1(i) !== 8'h00) begin errors++; $display("FAIL stream_rst_d1 inst%0d got %h exp 00", i, act_d1(i)); end
            if (act_d2(i) !== 8'h00) begin errors++; $display("FAIL stream_rst_d2 inst%0d got %h exp 00", i, act_d2(i)); end
            if (act_v(i)  !== 1'b0)  begin errors++; $display("FAIL stream_rst_valid inst%0d got %b exp 0", i, act_v(i)); end
        end
        // Remaining two cycles of the stream arrive while reset is held.
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_v(i) !== 1'b0) begin errors++; $display("FAIL held_rst_valid inst%0d got %b exp 0", i, act_v(i)); end
        end
        #3 reset_n = 1'b1;
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 3'd1);
        for (int i = 0; i < 2; i++) begin
            checks += 2;
            if (act_d1(i) !== 8'h00) begin errors++; $display("FAIL post_rst_r1 inst%0d got %h exp 00", i, act_d1(i)); end
            if (act_v(i)  !== 1'b1)  begin errors++; $display("FAIL post_rst_valid inst%0d got %b exp 1", i, act_v(i)); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(1)), 3'($urandom_range(7)), 8'($urandom_range(255)),
                 ($urandom_range(3) != 0), 3'($urandom_range(7)), 3'($urandom_range(7)));
            for (int i = 0; i < 2; i++) begin
                checks += 3;
                if (act_d1(i) !== exp_d1[i]) begin errors++; $display("FAIL rand_d1 inst%0d iter%0d got %h exp %h", i, n, act_d1(i), exp_d1[i]); end
                if (act_d2(i) !== exp_d2[i]) begin errors++; $display("FAIL rand_d2 inst%0d iter%0d got %h exp %h", i, n, act_d2(i), exp_d2[i]); end
                if (act_v(i)  !== exp_v)     begin errors++; $display("FAIL rand_valid inst%0d iter%0d got %b exp %b", i, n, act_v(i), exp_v); end
            end
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = 3'd0;
        wr_data  = 8'h00;
        rd_en    = 1'b0;
        rd_addr1 = 3'd0;
        rd_addr2 = 3'd0;
        model_reset();
        #1;
        test_reset();
        test_read_hold();
        test_zero_reg();
        test_collision();
        test_back_to_back();
        test_reset_streaming();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
